// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
//   fetch_entry_t : one queued {pc, instruction} pair handed to dispatch
//   fetch_state_t : fetch state machine encoding
//   INSTR_BYTES   : size of one instruction word in bytes
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        DONE  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries between the ROM capture point and dispatch.
//   clk, reset : clock, asynchronous active-high reset
//   push/wdata : enqueue one entry
//   pop        : advance the head
//   flush      : synchronous empty (wins over push/pop)
//   head       : entry at the head (don't-care when count == 0)
//   count      : entries held, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is only consumed when count != 0.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !flush && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && !flush && count == '0));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the ROM, and queues {pc, instr} pairs
// toward dispatch with a valid/ready handshake. Redirects flush the queue
// and reload the PC; fetching stops once the PC runs off the end of memory.
//   clk, reset        : clock, asynchronous active-high reset
//   imem_address      : ROM byte address (always equals pc)
//   imem_instruction  : combinational ROM data for imem_address
//   redirect_valid/pc : flush and restart at redirect_pc (low 2 bits dropped)
//   out_valid/ready   : head-of-queue handshake
//   out_pc/out_instr  : head entry
//   occupancy         : entries held
//   fetch_done        : PC past end of memory, no further fetches
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'h0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [63:0]   imem_address,
    input  logic [31:0]   imem_instruction,
    input  logic          redirect_valid,
    input  logic [63:0]   redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic [CW-1:0] occupancy,
    output logic          fetch_done
);

    fetch_state_t state, state_next;
    logic [63:0]  pc, pc_next;
    logic [63:0]  redirect_aligned;
    logic         pc_in_range;
    logic         room;
    logic         push;
    logic         pop;
    fetch_entry_t wdata;
    fetch_entry_t head;

    // A whole instruction word must lie inside memory before it is read.
    function automatic logic in_range(input logic [63:0] addr);
        return (addr + 64'(INSTR_BYTES - 1)) < 64'(IMEM_BYTES);
    endfunction

    assign redirect_aligned = redirect_pc & ~64'h3;
    assign pc_in_range      = in_range(pc);
    assign out_valid        = (occupancy != '0);

    // A full queue still has room when the head leaves this cycle, which
    // puts out_ready on the push-enable path.
    assign room = (occupancy < CW'(DEPTH)) || (out_valid && out_ready);

    // Redirect squashes both sides of the queue for this cycle. The range
    // check is on the current PC, so an out-of-range word is never captured.
    assign pop  = out_valid && out_ready && !redirect_valid;
    assign push = !redirect_valid && (state == FETCH) && pc_in_range && room;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect_valid) begin
            pc_next    = redirect_aligned;
            state_next = in_range(redirect_aligned) ? FETCH : DONE;
        end else begin
            if (push) pc_next = pc + 64'(INSTR_BYTES);
            if (state == FETCH && !pc_in_range) state_next = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    assign wdata = '{pc: pc, instr: imem_instruction};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .head  (head),
        .count (occupancy)
    );

    assign imem_address = pc;
    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign fetch_done   = (state == DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int IMEM  = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;
    logic        fetch_done;

    instr_fetch_unit #(.DEPTH(DEPTH), .IMEM_BYTES(IMEM), .RESET_PC(64'h0)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instr        (out_instr),
        .occupancy        (occupancy),
        .fetch_done       (fetch_done)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [IMEM/4];
    always_comb
        imem_instruction = (imem_address < 64'(IMEM)) ? rom[imem_address[9:2]] : 32'hBADBAD00;

    int total = 0;
    int bad   = 0;

    // Reference model: a list of queued entries plus a fetch PC. An entry is
    // fetched whenever its whole word is inside memory and the queue has
    // space (counting a departing head); fetching is "done" when the PC is
    // out of range and did not just step there.
    fetch_entry_t mq[$];
    fetch_entry_t exp_q[$];
    logic [63:0]  mpc;
    bit           madv;
    int           exp_occ;
    logic [63:0]  exp_addr;
    bit           exp_done;
    bit           chk = 1'b0;

    function automatic bit in_rng(input logic [63:0] a);
        return (a + 64'd3) < 64'(IMEM);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT each cycle away from the active edge and
    // retires an expected entry whenever the DUT hands one to dispatch.
    always @(negedge clk) begin
        if (chk && !reset) begin
            check("occupancy", 64'(occupancy), 64'(exp_occ));
            check("imem_address", imem_address, exp_addr);
            check("fetch_done", 64'(fetch_done), 64'(exp_done));
            check("out_valid", 64'(out_valid), 64'(exp_occ > 0));
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 64'(1), 64'(0));
                end else begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", 64'(out_instr), 64'(e.instr));
                end
            end
        end
    end

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        mpc  = 64'h0;
        madv = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model, wait past the edge.
    task automatic step(input bit rv, input logic [63:0] rp, input bit rdy);
        int sz;
        bit pop;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        exp_occ  = mq.size();
        exp_addr = mpc;
        exp_done = !in_rng(mpc) && !madv;
        sz  = mq.size();
        pop = !rv && rdy && sz > 0;
        if (pop) exp_q.push_back(mq[0]);
        if (rv) begin
            mq.delete();
            mpc  = {rp[63:2], 2'b00};
            madv = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (in_rng(mpc) && (sz < DEPTH || pop)) begin
                mq.push_back('{pc: mpc, instr: rom[mpc[9:2]]});
                mpc  = mpc + 64'd4;
                madv = 1'b1;
            end else begin
                madv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < IMEM/4; i++) rom[i] = $urandom;

        // Reset values
        #12;
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fetch_done", 64'(fetch_done), 64'd0);
        check("rst_imem_address", imem_address, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk = 1'b1;

        // Stream with dispatch always ready
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        // Backpressure until full, then release (push+pop while full)
        step(1'b1, 64'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        // Redirect to 0x43 with three entries queued and dispatch ready
        step(1'b1, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 64'h43, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        // End of memory, with and without backpressure
        step(1'b1, 64'd1016, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 64'd1016, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 64'd2000, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 64'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit          rv;
            logic [63:0] rp;
            rv = ($urandom_range(0, 15) == 0);
            rp = ($urandom_range(0, 2) == 0) ? 64'(990 + $urandom_range(0, 50))
                                              : 64'($urandom_range(0, IMEM - 1));
            step(rv, rp, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset with three entries queued
        step(1'b1, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        chk = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_occupancy", 64'(occupancy), 64'd0);
        check("async_imem_address", imem_address, 64'h0);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, '0, ($urandom_range(0, 1) != 0));

        check("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end fetch stage that sits directly upstream of the instruction ROM and feeds the dispatch/rename logic. It owns the program counter, drives the ROM byte address, captures the combinational ROM output, and buffers `{pc, instruction}` pairs in a small queue toward dispatch using a valid/ready handshake. It accepts redirects from branch resolution or a ROB flush, and stops fetching cleanly at the end of instruction memory.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `IMEM_BYTES`, 1024: instruction memory size in bytes; must match the ROM.
- `RESET_PC`, 64'h0: PC loaded on reset.

- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `imem_address`  out  64  byte address to the ROM; equals `pc`.
- `imem_instruction`  in  32  combinational ROM data for `imem_address`.
- `redirect_valid`  in  1  flush the queue and load `redirect_pc`.
- `redirect_pc`  in  64  new fetch address; bits [1:0] are forced to 0.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  dispatch accepts the head this cycle.
- `out_pc`  out  64  PC of the head entry.
- `out_instr`  out  32  instruction of the head entry.
- `occupancy`  out  $clog2(DEPTH)+1  entries held.
- `fetch_done`  out  1  PC is past the end of memory; fetching has stopped.

## Operation
- States:
  - FETCH: a push happens when `pc+3 < IMEM_BYTES` and there is room.
  - DONE: no pushes.
- Transitions:
  - FETCH→DONE when `pc+3 >= IMEM_BYTES`. This is evaluated combinationally, so no X instruction is ever enqueued.
  - DONE→FETCH only on a redirect whose `redirect_pc` is in range.
- Room: `occupancy < DEPTH`, or (`out_valid && out_ready`). Simultaneous push and pop when full is allowed.
- Push: enqueue `{pc, imem_instruction}` and set `pc <= pc + 4` (64-bit wrap, never reached in practice).
- Pop: happens when `out_valid && out_ready`; the head advances.
- Redirect has priority over push and pop in the same cycle:
  - queue is emptied and `occupancy <= 0`;
  - `pc <= {redirect_pc[63:2], 2'b00}`;
  - a pop in that cycle is discarded (dispatch must treat it as squashed);
  - state is re-evaluated from the new PC on the next cycle.
- Head-of-queue outputs:
  - `out_pc` and `out_instr` are stable while `out_valid && !out_ready` (no redirect).
  - When `out_valid` is 0 they are don't-care.
- `fetch_done` is 1 exactly in DONE.
- Queue pointers wrap modulo DEPTH; occupancy saturates at neither bound (it is correct by construction). Assertion: no push when full without a pop, no pop when empty.

## Timing
- Reset values (asynchronous):
  - `pc = RESET_PC`, state FETCH;
  - queue empty, `occupancy = 0`, `out_valid = 0`, `fetch_done = 0`;
  - `imem_address = RESET_PC`.
- Fetch latency: PC presented in cycle N → entry visible at the head with `out_valid = 1` in cycle N+1. No bypass from ROM to output.
- Throughput: one instruction per cycle when dispatch is ready.
- Redirect latency:
  - redirect in cycle N → cycle N+1: `imem_address = redirect_pc`, `out_valid = 0`;
  - cycle N+2: `out_pc = redirect_pc`.
- Combinational paths:
  - `out_ready` → push enable (room when full);
  - `imem_address` → `imem_instruction` → queue write data.
  - Outputs other than `imem_address` come from registers or the queue read mux.
- Reset asserted mid-operation clears everything immediately; the first push is in the first cycle after deassertion.

## Structure
- Package `fetch_pkg`:
  - `fetch_entry_t` struct `{logic [63:0] pc; logic [31:0] instr;}`;
  - `fetch_state_t` enum {FETCH, DONE};
  - constant `INSTR_BYTES = 4`.
- Sub-module `fetch_fifo`: parameterised circular buffer of `fetch_entry_t` with push, pop, synchronous flush, and count. `instr_fetch_unit` holds the PC, the state machine, and the room/redirect priority logic.

## Test plan
- Stream:
  - Stimulus: reset, `out_ready = 1`, ROM words W0..W3.
  - Response: `out_pc` = 0, 4, 8, 12 on consecutive cycles starting in cycle 1, with `out_instr` = W0..W3.
- Backpressure:
  - Stimulus: `out_ready = 0` for 8 cycles, DEPTH = 4.
  - Response: `occupancy` reaches 4 and `pc` holds at 16. After releasing `out_ready`, PCs 0..12 drain in order, then 16 follows with no bubble.
- Full plus simultaneous pop:
  - Stimulus: queue full, then `out_ready = 1`.
  - Response: `occupancy` stays 4 while both push and pop occur every cycle.
- Redirect:
  - Stimulus: `redirect_valid = 1`, `redirect_pc = 0x43` (low bits are forced to 0) while the queue holds 3 entries and `out_ready = 1`.
  - Response: next cycle `occupancy = 0` and `imem_address = 0x40`; the cycle after, `out_pc = 0x40`.
- End of memory:
  - Stimulus: `IMEM_BYTES = 1024`, redirect to 1016.
  - Response: PCs 1016 and 1020 are enqueued, then `fetch_done = 1`, nothing further is pushed, and no X appears on `out_instr`. A redirect to 0 clears `fetch_done`.
- Reset mid-stream:
  - Stimulus: assert `reset` asynchronously while `occupancy = 3`.
  - Response: `out_valid = 0`, `occupancy = 0`, and `imem_address = 0` immediately, before the next edge.
